rl_ram_1r1w_arb: RTL and testbench
==================================

RL_RAM_1R1W_ARB -- requirements
Module: rl_ram_1r1w_arb

Interface
REQ-001 SHALL have parameter ABITS, default 10: RAM address width.
REQ-002 SHALL have parameter DBITS, default 32: RAM data width; byte-enable width BBITS=(DBITS+7)/8.
REQ-003 SHALL have parameter NREQ, default 4, legal range 2..8: number of requesters on each side.
REQ-004 SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have ports rreq_i, input, NREQ bits, and raddr_i, input, NREQ x ABITS: per-requester read request and read address.
REQ-007 SHALL have ports rgnt_o, output, NREQ bits, one-hot or zero, and rvalid_o, output, NREQ bits, one-hot or zero: read grant and read-data valid.
REQ-008 SHALL have port rdata_o, output, DBITS: shared read data, qualified by rvalid_o.
REQ-009 SHALL have ports wreq_i, input, NREQ bits; waddr_i, input, NREQ x ABITS; wdata_i, input, NREQ x DBITS; wbe_i, input, NREQ x BBITS: per-requester write request, address, data and byte enables.
REQ-010 SHALL have port wgnt_o, output, NREQ bits, one-hot or zero: write grant.
REQ-011 SHALL have RAM-side outputs ram_raddr_o (ABITS), ram_re_o (1), ram_waddr_o (ABITS), ram_din_o (DBITS), ram_we_o (1), ram_be_o (BBITS), and RAM-side input ram_dout_i (DBITS); these connect directly to the 1r1w RAM wrapper's ports of the same meaning.

Function
REQ-012 SHALL arbitrate the read side and the write side independently; at most one read and one write are issued per cycle.
REQ-013 SHALL grant combinationally in the cycle in which the request is seen; a requester holds its request and address stable until it is granted; the grant cycle is the transfer cycle.
REQ-014 SHALL use round-robin per side: the search starts at the last granted index + 1 and wraps from NREQ-1 to 0; the pointer updates only on a grant.
REQ-015 SHALL drive ram_re_o = |rgnt_o and ram_raddr_o = raddr_i[granted]; ram_we_o = |wgnt_o, ram_waddr_o/ram_din_o/ram_be_o = the granted requester's fields.
REQ-016 SHALL assert rvalid_o[i] exactly 1 cycle after rgnt_o[i] and present rdata_o = ram_dout_i in that cycle; back-to-back reads every cycle are supported (throughput 1/cycle).
REQ-017 SHALL drive ram_we_o=0, ram_re_o=0 and all grants 0 when no request is pending; the RAM-side address/data outputs are don't-care in that case.
REQ-018 SHALL leave same-address read/write collisions in the same cycle to the RAM wrapper's contention bypass; the arbiter adds no ordering between sides.
REQ-019 SHALL keep a request withdrawn before grant as a protocol violation, unchecked in RTL and flagged by bench assertion.

Reset
REQ-020 SHALL, while rst_ni=0, force rgnt_o, wgnt_o, rvalid_o, ram_re_o and ram_we_o to 0 and set both round-robin pointers to NREQ-1, so requester 0 has first priority.
REQ-021 SHALL discard a read in flight when reset is asserted: no rvalid_o follows reset release.

Configuration
REQ-022 SHALL support macro RL_RAM_ARB_LOCK_EN; when it is defined, it adds input ports rlock_i and wlock_i, NREQ bits each.
REQ-023 SHALL, with RL_RAM_ARB_LOCK_EN defined, keep the grant on the same requester every cycle while that requester holds both its request and its lock bit, ignoring round-robin; the lock ends on the first cycle without request or lock.
REQ-024 SHALL, without RL_RAM_ARB_LOCK_EN, have no lock ports and use pure round-robin.

Structure
REQ-025 SHALL place the NREQ limit constant and the grant-index typedef (logic [2:0]) in package rl_ram_arb_pkg.
REQ-026 SHALL implement arbitration in one sub-module, rl_rr_arbiter (request vector in; one-hot grant and pointer out; optional lock), instantiated once per side.

Verification
REQ-027 SHALL cover: reset release, rreq_i=4'b1111 held -> grants 0,1,2,3,0 on consecutive cycles, rvalid_o follows each one cycle later.
REQ-028 SHALL cover: requester 2 reads address 0x3 holding 0xDEADBEEF -> rgnt_o=4'b0100 in cycle n, rvalid_o=4'b0100 and rdata_o=0xDEADBEEF in cycle n+1.
REQ-029 SHALL cover: wreq_i=4'b1010 with wbe_i=4'b0011 -> requester 1 granted first, then requester 3, ram_be_o=4'b0011 each.
REQ-030 SHALL cover: a simultaneous read and write from different requesters -> both granted in the same cycle, ram_re_o=ram_we_o=1.
REQ-031 SHALL cover, with RL_RAM_ARB_LOCK_EN defined: requester 1 holds rreq and rlock for 3 cycles while all requesters are requesting -> rgnt_o=4'b0010 for 3 cycles, then 4'b0100.
REQ-032 SHALL cover: rst_ni dropped the cycle after a read grant -> rvalid_o stays 0, and after release requester 0 is granted first.

Source files
------------

// File: rtl/rl_ram_arb_pkg.sv
// Shared constants and types for the 1r1w RAM port arbiter.
// Holds the requester-count limit and the grant-index type used by both sides.
// No logic, no latency, no flow control.
package rl_ram_arb_pkg;

    localparam int unsigned NREQ_MAX = 8;

    typedef logic [2:0] gidx_t;

endpackage

// File: rtl/rl_rr_arbiter.sv
// Round-robin arbiter with optional per-requester lock, one instance per RAM side.
// Latency: grant is combinational in the request cycle; pointer updates on the following edge.
// Backpressure: a requester not granted simply keeps requesting; nothing is queued here.
module rl_rr_arbiter
    import rl_ram_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [NREQ-1:0] req_i,
    input  logic [NREQ-1:0] lock_i,
    output logic [NREQ-1:0] gnt_o,
    output gidx_t           ptr_o
);

    gidx_t           r_ptr;
    logic            r_lock;
    logic [NREQ-1:0] w_last;
    logic [NREQ-1:0] w_gnt;
    logic            w_hold;
    logic            w_any;
    int              w_sel;
    int              w_best;
    int              w_d;

    // Distance from the last winner, 1..NREQ; the closest requester wins.
    always_comb begin
        w_last = '0;
        w_sel  = 0;
        w_best = int'(NREQ) + 1;
        w_d    = 0;
        for (int i = 0; i < int'(NREQ); i++) begin
            w_last[i] = (i == int'(r_ptr));
            w_d = i - int'(r_ptr);
            if (w_d <= 0) begin
                w_d = w_d + int'(NREQ);
            end
            if (req_i[i] && (w_d < w_best)) begin
                w_best = w_d;
                w_sel  = i;
            end
        end
        w_any  = |req_i;
        w_hold = r_lock && |(w_last & req_i & lock_i);
        w_gnt  = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            w_gnt[i] = w_hold ? w_last[i] : (w_any && (i == w_sel));
        end
    end

    assign gnt_o = rst_ni ? w_gnt : '0;
    assign ptr_o = r_ptr;

    // Lock is only honoured for a requester that already won while holding its lock bit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr  <= gidx_t'(NREQ - 1);
            r_lock <= 1'b0;
        end else begin
            if (|gnt_o) begin
                r_ptr <= w_hold ? r_ptr : gidx_t'(w_sel);
            end
            r_lock <= |(gnt_o & lock_i);
        end
    end

endmodule

// File: rtl/rl_ram_1r1w_arb.sv
// NREQ-way read and write arbiter in front of a 1r1w RAM; RL_RAM_ARB_LOCK_EN adds lock ports.
// Latency: grant and RAM command in the request cycle; rvalid_o/rdata_o one cycle later.
// Backpressure: losers hold request and fields stable until granted; one read and one write per cycle.
module rl_ram_1r1w_arb
    import rl_ram_arb_pkg::*;
#(
    parameter  int unsigned ABITS = 10,
    parameter  int unsigned DBITS = 32,
    parameter  int unsigned NREQ  = 4,
    localparam int unsigned BBITS = (DBITS + 7) / 8
) (
    input  logic                        rst_ni,
    input  logic                        clk_i,
    input  logic [NREQ-1:0]             rreq_i,
    input  logic [NREQ-1:0][ABITS-1:0]  raddr_i,
    output logic [NREQ-1:0]             rgnt_o,
    output logic [NREQ-1:0]             rvalid_o,
    output logic [DBITS-1:0]            rdata_o,
    input  logic [NREQ-1:0]             wreq_i,
    input  logic [NREQ-1:0][ABITS-1:0]  waddr_i,
    input  logic [NREQ-1:0][DBITS-1:0]  wdata_i,
    input  logic [NREQ-1:0][BBITS-1:0]  wbe_i,
    output logic [NREQ-1:0]             wgnt_o,
`ifdef RL_RAM_ARB_LOCK_EN
    input  logic [NREQ-1:0]             rlock_i,
    input  logic [NREQ-1:0]             wlock_i,
`endif
    output logic [ABITS-1:0]            ram_raddr_o,
    output logic                        ram_re_o,
    output logic [ABITS-1:0]            ram_waddr_o,
    output logic [DBITS-1:0]            ram_din_o,
    output logic                        ram_we_o,
    output logic [BBITS-1:0]            ram_be_o,
    input  logic [DBITS-1:0]            ram_dout_i
);

    if ((NREQ < 2) || (NREQ > NREQ_MAX)) begin : g_bad_nreq
        $error("rl_ram_1r1w_arb: NREQ must be within 2..%0d", NREQ_MAX);
    end

    logic [NREQ-1:0] w_rlock;
    logic [NREQ-1:0] w_wlock;
    logic [NREQ-1:0] w_rgnt;
    logic [NREQ-1:0] w_wgnt;
    logic [NREQ-1:0] r_rvalid;
    gidx_t           w_rptr;
    gidx_t           w_wptr;
    logic            w_unused_ptr;

`ifdef RL_RAM_ARB_LOCK_EN
    assign w_rlock = rlock_i;
    assign w_wlock = wlock_i;
`else
    assign w_rlock = '0;
    assign w_wlock = '0;
`endif

    rl_rr_arbiter #(.NREQ(NREQ)) u_rd_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  (rreq_i),
        .lock_i (w_rlock),
        .gnt_o  (w_rgnt),
        .ptr_o  (w_rptr)
    );

    rl_rr_arbiter #(.NREQ(NREQ)) u_wr_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  (wreq_i),
        .lock_i (w_wlock),
        .gnt_o  (w_wgnt),
        .ptr_o  (w_wptr)
    );

    assign w_unused_ptr = ^{w_rptr, w_wptr};

    // Grants are one-hot, so an AND-OR mux selects the winner's fields.
    always_comb begin
        ram_raddr_o = '0;
        ram_waddr_o = '0;
        ram_din_o   = '0;
        ram_be_o    = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (w_rgnt[i]) begin
                ram_raddr_o = raddr_i[i];
            end
            if (w_wgnt[i]) begin
                ram_waddr_o = waddr_i[i];
                ram_din_o   = wdata_i[i];
                ram_be_o    = wbe_i[i];
            end
        end
    end

    assign rgnt_o   = w_rgnt;
    assign wgnt_o   = w_wgnt;
    assign ram_re_o = |w_rgnt;
    assign ram_we_o = |w_wgnt;

    // Async reset clears a read in flight so no rvalid_o appears after release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rvalid <= '0;
        end else begin
            r_rvalid <= w_rgnt;
        end
    end

    assign rvalid_o = r_rvalid;
    assign rdata_o  = ram_dout_i;

endmodule

// File: tb/tb_rl_ram_1r1w_arb.sv
// Bench for rl_ram_1r1w_arb: directed scenarios plus random traffic against a reference model.
// Includes a behavioural RAM on the RAM-side ports; lock scenarios run when RL_RAM_ARB_LOCK_EN is set.
module tb_rl_ram_1r1w_arb;

    localparam int ABITS = 10;
    localparam int DBITS = 32;
    localparam int NREQ  = 4;
    localparam int BBITS = 4;
    localparam int DEPTH = 1 << ABITS;

    logic                       clk_i = 1'b0;
    logic                       rst_ni = 1'b0;
    logic [NREQ-1:0]            rreq_i = '0;
    logic [NREQ-1:0][ABITS-1:0] raddr_i = '0;
    logic [NREQ-1:0]            rgnt_o, rvalid_o, wgnt_o;
    logic [DBITS-1:0]           rdata_o;
    logic [NREQ-1:0]            wreq_i = '0;
    logic [NREQ-1:0][ABITS-1:0] waddr_i = '0;
    logic [NREQ-1:0][DBITS-1:0] wdata_i = '0;
    logic [NREQ-1:0][BBITS-1:0] wbe_i = '0;
    logic [NREQ-1:0]            rlock_i = '0;
    logic [NREQ-1:0]            wlock_i = '0;
    logic [ABITS-1:0]           ram_raddr_o, ram_waddr_o;
    logic                       ram_re_o, ram_we_o;
    logic [DBITS-1:0]           ram_din_o;
    logic [DBITS-1:0]           ram_dout_i = '0;
    logic [BBITS-1:0]           ram_be_o;

    always #5 clk_i = ~clk_i;

    rl_ram_1r1w_arb #(.ABITS(ABITS), .DBITS(DBITS), .NREQ(NREQ)) dut (
        .rst_ni      (rst_ni),
        .clk_i       (clk_i),
        .rreq_i      (rreq_i),
        .raddr_i     (raddr_i),
        .rgnt_o      (rgnt_o),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .wreq_i      (wreq_i),
        .waddr_i     (waddr_i),
        .wdata_i     (wdata_i),
        .wbe_i       (wbe_i),
        .wgnt_o      (wgnt_o),
`ifdef RL_RAM_ARB_LOCK_EN
        .rlock_i     (rlock_i),
        .wlock_i     (wlock_i),
`endif
        .ram_raddr_o (ram_raddr_o),
        .ram_re_o    (ram_re_o),
        .ram_waddr_o (ram_waddr_o),
        .ram_din_o   (ram_din_o),
        .ram_we_o    (ram_we_o),
        .ram_be_o    (ram_be_o),
        .ram_dout_i  (ram_dout_i)
    );

    function automatic logic [DBITS-1:0] init_word(input int a);
        return DBITS'(a) * 32'h9E37_79B1;
    endfunction

    // Behavioural 1r1w RAM: read-before-write on a same-address collision.
    logic [DBITS-1:0] ram_mem [DEPTH];
    initial for (int a = 0; a < DEPTH; a++) ram_mem[a] = init_word(a);

    always @(posedge clk_i) begin
        if (ram_re_o) ram_dout_i <= ram_mem[ram_raddr_o];
        if (ram_we_o)
            for (int b = 0; b < BBITS; b++)
                if (ram_be_o[b]) ram_mem[ram_waddr_o][b*8 +: 8] <= ram_din_o[b*8 +: 8];
    end

    // Reference model state.
    logic [DBITS-1:0] shadow [DEPTH];
    initial for (int a = 0; a < DEPTH; a++) shadow[a] = init_word(a);
    int               m_rptr = NREQ - 1, m_wptr = NREQ - 1;
    bit               m_rlk = 1'b0, m_wlk = 1'b0;
    logic [NREQ-1:0]  exp_rv = '0;
    logic [DBITS-1:0] exp_rdata = '0;
    logic [NREQ-1:0]  prev_rpend = '0, prev_wpend = '0;

    logic [NREQ-1:0]  last_rgnt, last_wgnt, last_rvalid;
    logic [DBITS-1:0] last_rdata;
    logic [BBITS-1:0] last_be;
    logic             last_re, last_we;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Spec rule: a locked previous winner keeps the grant; otherwise search from last+1, wrapping.
    function automatic int rr_pick(input int ptr, input logic [NREQ-1:0] req,
                                   input logic [NREQ-1:0] lk, input bit lkact);
        if (lkact && req[ptr] && lk[ptr]) return ptr;
        for (int k = 1; k <= NREQ; k++)
            if (req[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        return -1;
    endfunction

    task automatic step();
        int rp, wp;
        logic [NREQ-1:0] er, ew;
        @(negedge clk_i);
        last_rgnt = rgnt_o;  last_wgnt = wgnt_o;  last_rvalid = rvalid_o;
        last_rdata = rdata_o; last_be = ram_be_o; last_re = ram_re_o; last_we = ram_we_o;
        if (!rst_ni) begin
            chk("rst_rgnt", rgnt_o, 0);
            chk("rst_wgnt", wgnt_o, 0);
            chk("rst_rvalid", rvalid_o, 0);
            chk("rst_re_we", {ram_re_o, ram_we_o}, 0);
            m_rptr = NREQ - 1; m_wptr = NREQ - 1; m_rlk = 0; m_wlk = 0;
            exp_rv = '0; prev_rpend = '0; prev_wpend = '0;
        end else begin
            chk("rhold", prev_rpend & ~rreq_i, 0);
            chk("whold", prev_wpend & ~wreq_i, 0);
            chk("rvalid", rvalid_o, exp_rv);
            if (exp_rv != 0) chk("rdata", rdata_o, exp_rdata);
            rp = rr_pick(m_rptr, rreq_i, rlock_i, m_rlk);
            wp = rr_pick(m_wptr, wreq_i, wlock_i, m_wlk);
            er = (rp >= 0) ? NREQ'(1) << rp : '0;
            ew = (wp >= 0) ? NREQ'(1) << wp : '0;
            chk("rgnt", rgnt_o, er);
            chk("wgnt", wgnt_o, ew);
            chk("ram_re", ram_re_o, rp >= 0);
            chk("ram_we", ram_we_o, wp >= 0);
            exp_rv = er;
            if (rp >= 0) begin
                chk("ram_raddr", ram_raddr_o, raddr_i[rp]);
                exp_rdata = shadow[raddr_i[rp]];
                m_rptr = rp;
            end
            if (wp >= 0) begin
                chk("ram_waddr", ram_waddr_o, waddr_i[wp]);
                chk("ram_din", ram_din_o, wdata_i[wp]);
                chk("ram_be", ram_be_o, wbe_i[wp]);
                for (int b = 0; b < BBITS; b++)
                    if (wbe_i[wp][b]) shadow[waddr_i[wp]][b*8 +: 8] = wdata_i[wp][b*8 +: 8];
                m_wptr = wp;
            end
            m_rlk = (rp >= 0) && rlock_i[rp];
            m_wlk = (wp >= 0) && wlock_i[wp];
            prev_rpend = rreq_i & ~er;
            prev_wpend = wreq_i & ~ew;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic drain();
        rlock_i = '0; wlock_i = '0;
        for (int n = 0; n < 3 * NREQ; n++) begin
            rreq_i = prev_rpend; wreq_i = prev_wpend;
            if (rreq_i == 0 && wreq_i == 0) break;
            step();
        end
        chk("drain_done", {prev_rpend, prev_wpend}, 0);
        rreq_i = '0; wreq_i = '0;
    endtask

    initial begin
        // Reset held with every requester asking: nothing may be granted.
        rreq_i = '1; wreq_i = '1;
        step();
        step();
        rst_ni = 1'b1;
        wreq_i = '0;
        for (int i = 0; i < NREQ; i++) raddr_i[i] = ABITS'(i + 8);

        // All four readers requesting: grants rotate 0,1,2,3,0.
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rr_seq", last_rgnt, NREQ'(1) << (k % NREQ));
            if (k > 0) chk("rr_rvalid", last_rvalid, NREQ'(1) << ((k - 1) % NREQ));
        end
        drain();
        step();

        // Requester 2 reads 0xDEADBEEF written at address 3.
        wreq_i = 4'b0001; waddr_i[0] = 10'h3; wdata_i[0] = 32'hDEAD_BEEF; wbe_i[0] = 4'hF;
        step();
        wreq_i = '0;
        rreq_i = 4'b0100; raddr_i[2] = 10'h3;
        step();
        chk("dbf_rgnt", last_rgnt, 4'b0100);
        rreq_i = '0;
        step();
        chk("dbf_rvalid", last_rvalid, 4'b0100);
        chk("dbf_rdata", last_rdata, 32'hDEAD_BEEF);

        // Writers 1 and 3 with byte enables 0011.
        wreq_i = 4'b1010; waddr_i[1] = 10'h5; waddr_i[3] = 10'h6;
        wdata_i[1] = $urandom; wdata_i[3] = $urandom; wbe_i[1] = 4'b0011; wbe_i[3] = 4'b0011;
        step();
        chk("wr_first", last_wgnt, 4'b0010);
        chk("wr_be1", last_be, 4'b0011);
        wreq_i = 4'b1000;
        step();
        chk("wr_second", last_wgnt, 4'b1000);
        chk("wr_be3", last_be, 4'b0011);
        wreq_i = '0;

        // Simultaneous read and write from different requesters.
        rreq_i = 4'b0001; raddr_i[0] = 10'h5;
        wreq_i = 4'b0100; waddr_i[2] = 10'h7; wdata_i[2] = $urandom; wbe_i[2] = 4'hF;
        step();
        chk("both_gnt", {last_rgnt, last_wgnt}, {4'b0001, 4'b0100});
        chk("both_re_we", {last_re, last_we}, 2'b11);
        rreq_i = '0; wreq_i = '0;
        step();

`ifdef RL_RAM_ARB_LOCK_EN
        // Requester 1 locks the read side for three cycles while everyone requests.
        rreq_i = 4'b0001;
        step();
        rreq_i = '1; rlock_i = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("lock_hold", last_rgnt, 4'b0010);
        end
        rlock_i = '0;
        step();
        chk("lock_release", last_rgnt, 4'b0100);
        drain();
`endif

        // Reset dropped the cycle after a read grant.
        rreq_i = 4'b0010;
        step();
        chk("rst_pre_gnt", last_rgnt, 4'b0010);
        rreq_i = '0;
        rst_ni = 1'b0;
        step();
        step();
        rst_ni = 1'b1;
        rreq_i = '1;
        step();
        chk("rst_post_first", last_rgnt, 4'b0001);
        chk("rst_no_rvalid", last_rvalid, 0);

        // Random traffic; pending requesters keep their fields stable.
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!prev_rpend[i]) begin
                    rreq_i[i]  = ($urandom_range(0, 2) != 0);
                    raddr_i[i] = ABITS'($urandom_range(0, 15));
                end
                if (!prev_wpend[i]) begin
                    wreq_i[i]  = ($urandom_range(0, 2) == 0);
                    waddr_i[i] = ABITS'($urandom_range(0, 15));
                    wdata_i[i] = $urandom;
                    wbe_i[i]   = BBITS'($urandom_range(0, 15));
                end
            end
`ifdef RL_RAM_ARB_LOCK_EN
            rlock_i = NREQ'($urandom);
            wlock_i = NREQ'($urandom);
`endif
            step();
        end
        drain();
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
